// File: rtl/mc_control_pkg.sv
// Shared encodings for the multi-cycle controller. State, opcode and memory-op
// codes must stay bit-identical to what main_mem decodes.
package mc_control_pkg;

    localparam logic [2:0] STATE_MEMORY = 3'd4;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_ALU_WB  = 3'd3,
        ST_MEMORY  = STATE_MEMORY,
        ST_LOAD_WB = 3'd5,
        ST_HALT    = 3'd6,
        ST_UNUSED  = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_ADDI = 4'h5,
        OP_LW   = 4'h6,
        OP_SW   = 4'h7,
        OP_BEQ  = 4'h8,
        OP_HALT = 4'hF
    } opcode_t;

    localparam logic [1:0] MEM_READ  = 2'b00;
    localparam logic [1:0] MEM_WRITE = 2'b01;
    localparam logic [1:0] MEM_IDLE  = 2'b10;

    function automatic logic [7:0] sext6(input logic [5:0] imm);
        return {{2{imm[5]}}, imm};
    endfunction

endpackage

// File: rtl/mc_control_reg_file.sv
// 8x8 register file: two asynchronous read ports, one synchronous write port,
// r0 hard-wired to zero on both the read and write side.
module mc_control_reg_file
    import mc_control_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_raddr_a,
    input  logic [2:0] i_raddr_b,
    output logic [7:0] o_rdata_a,
    output logic [7:0] o_rdata_b,
    input  logic       i_we,
    input  logic [2:0] i_waddr,
    input  logic [7:0] i_wdata
);

    logic [7:0] r_regs [8];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
        end else if (i_we && (i_waddr != 3'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == 3'd0) ? 8'd0 : r_regs[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == 3'd0) ? 8'd0 : r_regs[i_raddr_b];

endmodule

// File: rtl/mc_control.sv
// Multi-cycle sequencer and 8-bit datapath driving main_mem; one instruction
// in flight, memory request signals registered and idle outside MEMORY.
//   state      | meaning
//   FETCH   0  | IR <= instr, pc++
//   DECODE  1  | latch A, B, sign-extended imm
//   EXECUTE 2  | ALU / address check / branch
//   ALU_WB  3  | R[rd] <= ALUOut
//   MEMORY  4  | main_mem request held stable
//   LOAD_WB 5  | R[rd] <= load_value
//   HALT    6  | absorbing until reset
module mc_control
    import mc_control_pkg::*;
#(
    parameter int DMEM_WORDS = 3,
    parameter int PC_W       = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic [PC_W-1:0] o_pc,
    input  logic [15:0]     i_instr,
    output logic [2:0]      o_state,
    output logic [7:0]      o_mem_address,
    output logic [1:0]      o_mem_op,
    output logic [7:0]      o_mem_store_value,
    input  logic [7:0]      i_mem_load_value,
    output logic            o_halted,
    output logic            o_fault
);

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;
    logic [7:0]      r_a;
    logic [7:0]      r_b;
    logic [7:0]      r_imm;
    logic [7:0]      r_alu_out;
    logic [7:0]      r_mem_address;
    logic [7:0]      r_mem_store_value;
    logic [1:0]      r_mem_op;
    logic            r_halted;
    logic            r_fault;

    logic [3:0] w_op;
    logic [2:0] w_rd;
    logic [2:0] w_rs;
    logic [2:0] w_rt;
    logic [2:0] w_rb_addr;
    logic [7:0] w_rdata_a;
    logic [7:0] w_rdata_b;
    logic [7:0] w_ea;
    logic       w_ea_bad;
    logic [7:0] w_alu_result;
    logic       w_we;
    logic [7:0] w_wdata;

    assign w_op = r_ir[15:12];
    assign w_rd = r_ir[11:9];
    assign w_rs = r_ir[8:6];
    assign w_rt = r_ir[5:3];

    // SW and BEQ carry their second operand in the rd field
    assign w_rb_addr = ((w_op == OP_SW) || (w_op == OP_BEQ)) ? w_rd : w_rt;

    assign w_ea     = r_a + r_imm;
    assign w_ea_bad = int'(w_ea) >= DMEM_WORDS;

    assign w_we    = (r_state == ST_ALU_WB) || (r_state == ST_LOAD_WB);
    assign w_wdata = (r_state == ST_LOAD_WB) ? i_mem_load_value : r_alu_out;

    mc_control_reg_file u_reg_file (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rb_addr),
        .o_rdata_a (w_rdata_a),
        .o_rdata_b (w_rdata_b),
        .i_we      (w_we),
        .i_waddr   (w_rd),
        .i_wdata   (w_wdata)
    );

    always_comb begin
        w_alu_result = r_a + r_b;
        case (w_op)
            OP_SUB:  w_alu_result = r_a - r_b;
            OP_AND:  w_alu_result = r_a & r_b;
            OP_OR:   w_alu_result = r_a | r_b;
            OP_ADDI: w_alu_result = r_a + r_imm;
            default: w_alu_result = r_a + r_b;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state           <= ST_FETCH;
            r_pc              <= '0;
            r_ir              <= '0;
            r_a               <= '0;
            r_b               <= '0;
            r_imm             <= '0;
            r_alu_out         <= '0;
            r_mem_address     <= '0;
            r_mem_store_value <= '0;
            r_mem_op          <= MEM_IDLE;
            r_halted          <= 1'b0;
            r_fault           <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    r_ir    <= i_instr;
                    r_pc    <= r_pc + PC_W'(1);
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_a     <= w_rdata_a;
                    r_b     <= w_rdata_b;
                    r_imm   <= sext6(r_ir[5:0]);
                    r_state <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    case (w_op)
                        OP_NOP: r_state <= ST_FETCH;
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                            r_alu_out <= w_alu_result;
                            r_state   <= ST_ALU_WB;
                        end
                        OP_LW, OP_SW: begin
                            if (w_ea_bad) begin
                                r_fault  <= 1'b1;
                                r_halted <= 1'b1;
                                r_state  <= ST_HALT;
                            end else begin
                                r_mem_address <= w_ea;
                                r_mem_op      <= (w_op == OP_LW) ? MEM_READ : MEM_WRITE;
                                if (w_op == OP_SW) r_mem_store_value <= r_b;
                                r_state       <= ST_MEMORY;
                            end
                        end
                        OP_BEQ: begin
                            // pc already points past the branch
                            if (r_a == r_b) r_pc <= r_pc + PC_W'($signed(r_imm));
                            r_state <= ST_FETCH;
                        end
                        OP_HALT: begin
                            r_halted <= 1'b1;
                            r_state  <= ST_HALT;
                        end
                        default: begin
                            r_fault  <= 1'b1;
                            r_halted <= 1'b1;
                            r_state  <= ST_HALT;
                        end
                    endcase
                end
                ST_ALU_WB: r_state <= ST_FETCH;
                ST_MEMORY: begin
                    r_mem_op <= MEM_IDLE;
                    r_state  <= (w_op == OP_LW) ? ST_LOAD_WB : ST_FETCH;
                end
                ST_LOAD_WB: r_state <= ST_FETCH;
                ST_HALT: begin
                    r_halted <= 1'b1;
                    r_mem_op <= MEM_IDLE;
                end
                default: begin
                    r_mem_op <= MEM_IDLE;
                    r_state  <= ST_FETCH;
                end
            endcase
        end
    end

    assign o_pc              = r_pc;
    assign o_state           = r_state;
    assign o_mem_address     = r_mem_address;
    assign o_mem_op          = r_mem_op;
    assign o_mem_store_value = r_mem_store_value;
    assign o_halted          = r_halted;
    assign o_fault           = r_fault;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: ROM and main_mem models around the DUT, compared
// against an instruction-level reference model of the ISA.
module tb_mc_control;

    logic        clk;
    logic        rst;
    logic [7:0]  pc;
    logic [15:0] instr;
    logic [2:0]  state;
    logic [7:0]  mem_address;
    logic [1:0]  mem_op;
    logic [7:0]  mem_store_value;
    logic [7:0]  mem_load_value;
    logic        halted;
    logic        fault;

    mc_control dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .o_pc              (pc),
        .i_instr           (instr),
        .o_state           (state),
        .o_mem_address     (mem_address),
        .o_mem_op          (mem_op),
        .o_mem_store_value (mem_store_value),
        .i_mem_load_value  (mem_load_value),
        .o_halted          (halted),
        .o_fault           (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] rom [256];
    assign instr = rom[pc];

    logic [7:0] pre  [3];
    logic [7:0] dmem [3];
    bit         preload_en;

    // main_mem: acts on the posedge that ends MEMORY, load_value registered
    always @(posedge clk) begin
        if (rst) begin
            if (preload_en) for (int i = 0; i < 3; i++) dmem[i] <= pre[i];
        end else if (state == 3'd4 && mem_address < 8'd3) begin
            if (mem_op == 2'b00) mem_load_value <= dmem[mem_address];
            else if (mem_op == 2'b01) dmem[mem_address] <= mem_store_value;
        end
    end

    int obs_op[$], obs_addr[$], obs_data[$], trace[$];
    int idle_viol;

    always @(negedge clk) begin
        if (rst) begin
            obs_op.delete(); obs_addr.delete(); obs_data.delete(); trace.delete();
            idle_viol = 0;
        end else begin
            trace.push_back(int'(state));
            if (state == 3'd4) begin
                obs_op.push_back(int'(mem_op));
                obs_addr.push_back(int'(mem_address));
                obs_data.push_back(int'(mem_store_value));
            end else if (mem_op != 2'b10) begin
                idle_viol++;
            end
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int lo);
        return {op[3:0], rd[2:0], rs[2:0], lo[5:0]};
    endfunction

    function automatic logic [15:0] rtype(input int op, input int rd, input int rs, input int rt);
        return enc(op, rd, rs, rt * 8);
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    endtask

    int         exp_op[$], exp_addr[$], exp_data[$];
    logic [7:0] exp_mem [3];
    logic [7:0] exp_pc;
    bit         exp_fault;
    int         exp_cycles;

    // ISA-level reference: 3 cycles common front end, +1 for ALU/SW, +2 for LW
    task automatic run_model();
        logic [7:0]  r [8];
        logic [7:0]  m [3];
        logic [7:0]  p, imm, ea;
        logic [15:0] ins;
        logic [3:0]  op;
        logic [2:0]  rd, rs, rt;
        bit          done;
        int          cyc;
        exp_op.delete(); exp_addr.delete(); exp_data.delete();
        for (int i = 0; i < 8; i++) r[i] = 8'd0;
        for (int i = 0; i < 3; i++) m[i] = pre[i];
        p = 8'd0; cyc = 0; done = 0; exp_fault = 0;
        for (int step = 0; step < 500 && !done; step++) begin
            ins = rom[p];
            p   = p + 8'd1;
            op  = ins[15:12]; rd = ins[11:9]; rs = ins[8:6]; rt = ins[5:3];
            imm = {{2{ins[5]}}, ins[5:0]};
            cyc += 3;
            case (op)
                4'h0: ;
                4'h1: begin r[rd] = r[rs] + r[rt]; cyc += 1; end
                4'h2: begin r[rd] = r[rs] - r[rt]; cyc += 1; end
                4'h3: begin r[rd] = r[rs] & r[rt]; cyc += 1; end
                4'h4: begin r[rd] = r[rs] | r[rt]; cyc += 1; end
                4'h5: begin r[rd] = r[rs] + imm;   cyc += 1; end
                4'h6: begin
                    ea = r[rs] + imm;
                    if (ea >= 8'd3) begin exp_fault = 1; done = 1; end
                    else begin
                        r[rd] = m[ea];
                        exp_op.push_back(0); exp_addr.push_back(int'(ea)); exp_data.push_back(0);
                        cyc += 2;
                    end
                end
                4'h7: begin
                    ea = r[rs] + imm;
                    if (ea >= 8'd3) begin exp_fault = 1; done = 1; end
                    else begin
                        m[ea] = r[rd];
                        exp_op.push_back(1); exp_addr.push_back(int'(ea)); exp_data.push_back(int'(r[rd]));
                        cyc += 1;
                    end
                end
                4'h8: if (r[rs] == r[rd]) p = p + imm;
                4'hF: done = 1;
                default: begin exp_fault = 1; done = 1; end
            endcase
            r[0] = 8'd0;
        end
        exp_pc = p;
        exp_cycles = cyc;
        for (int i = 0; i < 3; i++) exp_mem[i] = m[i];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        preload_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_pc", pc, 0);
        chk("rst_mem_op", mem_op, 2'b10);
        chk("rst_mem_addr", mem_address, 0);
        chk("rst_store", mem_store_value, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);
        #1 rst = 1'b0;
    endtask

    task automatic run_test(input string name);
        int cyc, n;
        run_model();
        do_reset();
        cyc = 0;
        while (cyc < 2000) begin
            @(posedge clk);
            cyc++;
            #1;
            if (state == 3'd6) break;
        end
        @(negedge clk);
        #1;
        chk({name, "_cycles"}, cyc, exp_cycles);
        chk({name, "_pc"}, pc, exp_pc);
        chk({name, "_fault"}, fault, exp_fault);
        chk({name, "_halted"}, halted, 1);
        chk({name, "_naccess"}, obs_op.size(), exp_op.size());
        n = (obs_op.size() < exp_op.size()) ? obs_op.size() : exp_op.size();
        for (int i = 0; i < n; i++) begin
            chk({name, "_acc_op"}, obs_op[i], exp_op[i]);
            chk({name, "_acc_addr"}, obs_addr[i], exp_addr[i]);
            if (exp_op[i] == 1) chk({name, "_acc_data"}, obs_data[i], exp_data[i]);
        end
        for (int i = 0; i < 3; i++) chk({name, "_dmem"}, dmem[i], exp_mem[i]);
        chk({name, "_idle_op"}, idle_viol, 0);
    endtask

    int tr_exp [9] = '{0, 1, 2, 4, 5, 0, 1, 2, 6};

    initial begin
        int cyc, sel, rd, rs, rt;
        rst = 1'b1;
        preload_en = 1'b1;
        mem_load_value = 8'd0;
        pre[0] = 8'hEC; pre[1] = 8'h0A; pre[2] = 8'h02;

        clear_rom();
        rom[0] = enc(6, 1, 0, 1);
        run_test("lw_halt");
        for (int i = 0; i < 9; i++) chk("trace", (trace.size() > i) ? trace[i] : -1, tr_exp[i]);
        if (obs_addr.size() > 0) chk("lw_addr", obs_addr[0], 1);

        clear_rom();
        rom[0] = enc(6, 1, 0, 1);
        rom[1] = enc(6, 2, 0, 2);
        rom[2] = rtype(1, 3, 1, 2);
        rom[3] = rtype(2, 4, 2, 1);
        rom[4] = enc(7, 3, 0, 0);
        rom[5] = enc(7, 4, 0, 1);
        rom[6] = enc(7, 1, 0, 2);
        run_test("add_sub");
        chk("r3_sum", dmem[0], 8'h0C);
        chk("r4_wrap", dmem[1], 8'hF8);
        chk("r1_load", dmem[2], 8'h0A);

        clear_rom();
        rom[0] = enc(5, 1, 0, 5);
        rom[1] = enc(7, 1, 0, 2);
        rom[2] = enc(6, 2, 0, 2);
        rom[3] = enc(7, 2, 0, 0);
        run_test("sw_lw");
        if (obs_op.size() > 0) begin
            chk("sw_op", obs_op[0], 1);
            chk("sw_addr", obs_addr[0], 2);
            chk("sw_data", obs_data[0], 8'h05);
        end
        chk("r2_reload", dmem[0], 8'h05);

        clear_rom();
        rom[0] = enc(5, 1, 0, 3);
        rom[1] = enc(6, 2, 1, 0);
        run_test("ea_fault");
        chk("ea_fault_flag", fault, 1);
        chk("ea_fault_noacc", obs_op.size(), 0);

        clear_rom();
        rom[0] = enc(8, 0, 0, 3);
        rom[4] = enc(8, 0, 0, 62);
        run_test("beq_back");
        chk("beq_back_pc", pc, 8'd4);

        clear_rom();
        rom[0] = enc(5, 1, 0, 1);
        rom[1] = enc(8, 0, 0, 2);
        rom[4] = enc(8, 0, 1, 7);
        run_test("beq_ne");
        chk("beq_ne_pc", pc, 8'd6);

        clear_rom();
        rom[0] = 16'hA000;
        run_test("illegal");
        chk("illegal_fault", fault, 1);

        clear_rom();
        rom[0] = enc(5, 0, 0, 7);
        rom[1] = enc(7, 0, 0, 0);
        run_test("r0_zero");
        chk("r0_reads0", dmem[0], 8'h00);

        clear_rom();
        rom[0] = enc(5, 1, 0, 17);
        rom[1] = enc(7, 1, 0, 1);
        do_reset();
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            cyc++;
            #1;
            if (state == 3'd4) break;
        end
        chk("rm_reach_mem", state, 4);
        #2 preload_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("rm_state", state, 0);
        chk("rm_mem_op", mem_op, 2'b10);
        chk("rm_pc", pc, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rm_mem_kept", dmem[1], 8'h0A);
        run_test("rm_rerun");
        chk("rm_rerun_store", dmem[1], 8'h11);

        for (int t = 0; t < 25; t++) begin
            clear_rom();
            for (int i = 0; i < 3; i++) pre[i] = 8'($urandom);
            for (int i = 0; i < 12; i++) begin
                sel = $urandom_range(0, 19);
                rd = $urandom_range(0, 7);
                rs = $urandom_range(0, 7);
                rt = $urandom_range(0, 7);
                case (sel)
                    0:           rom[i] = 16'h0000;
                    1, 2:        rom[i] = rtype(1, rd, rs, rt);
                    3:           rom[i] = rtype(2, rd, rs, rt);
                    4:           rom[i] = rtype(3, rd, rs, rt);
                    5:           rom[i] = rtype(4, rd, rs, rt);
                    6, 7:        rom[i] = enc(5, rd, rs, $urandom_range(0, 63));
                    8, 9, 10:    rom[i] = enc(6, rd, ($urandom_range(0, 1) != 0) ? 0 : rs, $urandom_range(0, 3));
                    11, 12, 13:  rom[i] = enc(7, rd, ($urandom_range(0, 1) != 0) ? 0 : rs, $urandom_range(0, 3));
                    14, 15:      rom[i] = enc(8, rd, rs, $urandom_range(1, 3));
                    16:          rom[i] = enc($urandom_range(9, 14), rd, rs, rt);
                    default:     rom[i] = enc(5, rd, 0, $urandom_range(0, 63));
                endcase
            end
            run_test("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
